accel_layer_sequencer: RTL and testbench

Parametrised successor to the fully-connected layer control FSM. It takes a 5-word layer descriptor from the host databus and steps through one layer: it issues weight fetch requests, waits for data-valid, and drives the PE array chunk by chunk. It handles input counts that are not a multiple of the PE count by masking lanes on the last chunk, and applies write-back backpressure. It sits between the bus/SDRAM weight fetcher and the PE array / output BRAM.

---
 rtl/accel_layer_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_accel_layer_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_layer_sequencer.sv
// Purpose: steps one fully-connected layer: descriptor load, weight fetch, chunked MAC, write-back.
// Latency: per chunk REQ + WAIT(dval) + MAC + ADD_LAT cycles; one WRITE phase per neuron.
// Backpressure: WRITE holds wr_en and all addresses until out_ready; WAIT stalls until dval.
module accel_layer_sequencer #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int NUM_PE  = 16,
   parameter int CNT_W   = 10,
   parameter int ADD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              abort,
   input  logic [DATA_W-1:0] databus,
   input  logic              busrdwr,
   input  logic              dval,
   input  logic              out_ready,
   output logic              weight_req,
   output logic [ADDR_W-1:0] weight_addr,
   output logic [ADDR_W-1:0] in_addr,
   output logic              rd_bram,
   output logic              pe_enable,
   output logic              acc_clear,
   output logic [NUM_PE-1:0] lane_mask,
   output logic              add_done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] out_addr,
   output logic              neuron_done,
   output logic              layer_done,
   output logic              cfg_err,
   output logic              busy
);

   localparam int LOG2_PE = $clog2(NUM_PE);
   localparam int ACC_W   = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
   localparam logic [ADDR_W-1:0] PE_STEP  = ADDR_W'(NUM_PE);
   localparam logic [ACC_W-1:0]  ACC_LAST = ACC_W'(ADD_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CFG, S_REQ, S_WAIT, S_MAC, S_ACCUM, S_WRITE
   } state_t;

   state_t            state;
   logic [2:0]        word_idx;
   logic [ADDR_W-1:0] in_base;
   logic [ADDR_W-1:0] w_base;
   logic [ADDR_W-1:0] out_base;
   logic [CNT_W-1:0]  n_in;
   logic [CNT_W-1:0]  n_out;
   logic [CNT_W-1:0]  chunk_idx;
   logic [CNT_W-1:0]  neuron_idx;
   logic [ACC_W-1:0]  acc_cnt;
   logic              wr_q;

   logic [CNT_W-1:0]   n_out_word;
   logic [CNT_W:0]     chunks;
   logic [LOG2_PE-1:0] rem;
   logic               last_chunk;
   logic               last_neuron;
   logic               last_acc;
   logic               wr_accept;
   logic [NUM_PE-1:0]  tail_mask;
   logic [NUM_PE-1:0]  mac_mask;

   // one extra bit on the chunk count so n_in near 2^CNT_W cannot overflow
   assign n_out_word  = databus[CNT_W-1:0];
   assign chunks      = ({1'b0, n_in} + (CNT_W+1)'(NUM_PE - 1)) >> LOG2_PE;
   assign rem         = n_in[LOG2_PE-1:0];
   assign last_chunk  = ({1'b0, chunk_idx} == (chunks - 1'b1));
   assign last_neuron = (neuron_idx == (n_out - 1'b1));
   assign last_acc    = (acc_cnt == ACC_LAST);

   // the write completes in the cycle out_ready is seen; abort in that cycle cancels it
   assign wr_accept   = (state == S_WRITE) && out_ready && !abort;
   assign neuron_done = wr_accept;
   assign layer_done  = wr_accept && last_neuron;
   assign wr_en       = wr_q && !abort;
   assign busy        = (state != S_IDLE);

   // lanes below rem are live on a partial final chunk
   always_comb begin
      tail_mask = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         tail_mask[i] = (i < int'(rem));
      end
      mac_mask = (last_chunk && (rem != '0)) ? tail_mask : '1;
   end

   // layer control FSM; strobes are registered and set on entry to their state
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         word_idx    <= '0;
         in_base     <= '0;
         w_base      <= '0;
         out_base    <= '0;
         n_in        <= '0;
         n_out       <= '0;
         chunk_idx   <= '0;
         neuron_idx  <= '0;
         acc_cnt     <= '0;
         wr_q        <= 1'b0;
         weight_req  <= 1'b0;
         weight_addr <= '0;
         in_addr     <= '0;
         out_addr    <= '0;
         rd_bram     <= 1'b0;
         pe_enable   <= 1'b0;
         acc_clear   <= 1'b0;
         lane_mask   <= '0;
         add_done    <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         weight_req <= 1'b0;
         pe_enable  <= 1'b0;
         rd_bram    <= 1'b0;
         acc_clear  <= 1'b0;
         add_done   <= 1'b0;
         lane_mask  <= '0;
         if (abort && (state != S_IDLE)) begin
            state <= S_IDLE;
            wr_q  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (enable) begin
                     state    <= S_CFG;
                     cfg_err  <= 1'b0;
                     word_idx <= '0;
                  end
               end
               S_CFG: begin
                  if (busrdwr) begin
                     word_idx <= word_idx + 1'b1;
                     case (word_idx)
                        3'd0: in_base  <= databus[ADDR_W-1:0];
                        3'd1: w_base   <= databus[ADDR_W-1:0];
                        3'd2: out_base <= databus[ADDR_W-1:0];
                        3'd3: n_in     <= databus[CNT_W-1:0];
                        default: begin
                           n_out <= n_out_word;
                           if ((n_in == '0) || (n_out_word == '0)) begin
                              cfg_err <= 1'b1;
                              state   <= S_IDLE;
                           end else begin
                              in_addr     <= in_base;
                              weight_addr <= w_base;
                              out_addr    <= out_base;
                              chunk_idx   <= '0;
                              neuron_idx  <= '0;
                              acc_cnt     <= '0;
                              weight_req  <= 1'b1;
                              state       <= S_REQ;
                           end
                        end
                     endcase
                  end
               end
               S_REQ: state <= S_WAIT;
               S_WAIT: begin
                  if (dval) begin
                     state     <= S_MAC;
                     pe_enable <= 1'b1;
                     rd_bram   <= 1'b1;
                     acc_clear <= (chunk_idx == '0);
                     lane_mask <= mac_mask;
                  end
               end
               S_MAC: begin
                  state    <= S_ACCUM;
                  acc_cnt  <= '0;
                  add_done <= (ADD_LAT == 1);
               end
               S_ACCUM: begin
                  if (last_acc) begin
                     // weight rows are padded to whole chunks, so this never rewinds
                     weight_addr <= weight_addr + PE_STEP;
                     if (last_chunk) begin
                        wr_q  <= 1'b1;
                        state <= S_WRITE;
                     end else begin
                        chunk_idx  <= chunk_idx + 1'b1;
                        in_addr    <= in_addr + PE_STEP;
                        weight_req <= 1'b1;
                        state      <= S_REQ;
                     end
                  end else begin
                     acc_cnt  <= acc_cnt + 1'b1;
                     add_done <= ((acc_cnt + 1'b1) == ACC_LAST);
                  end
               end
               S_WRITE: begin
                  if (out_ready) begin
                     wr_q <= 1'b0;
                     if (last_neuron) begin
                        state <= S_IDLE;
                     end else begin
                        neuron_idx <= neuron_idx + 1'b1;
                        out_addr   <= out_addr + 1'b1;
                        in_addr    <= in_base;
                        chunk_idx  <= '0;
                        weight_req <= 1'b1;
                        state      <= S_REQ;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_accel_layer_sequencer.sv
// Bench for accel_layer_sequencer: scoreboard of expected MAC chunks, writes and layer ends.
// Main DUT uses ADD_LAT=1; a second instance with ADD_LAT=3 checks adder-tree timing.
// Inputs change 1 time unit after posedge; the monitor samples on negedge.
module tb_accel_layer_sequencer;

   localparam int NPE = 16;

   typedef struct {
      logic [15:0] ia;
      logic [15:0] wa;
      logic [15:0] mask;
      logic        clr;
   } mac_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0, enable3 = 1'b0, abort = 1'b0, busrdwr = 1'b0;
   logic dval = 1'b0, dval3 = 1'b0, out_ready = 1'b1, out_ready3 = 1'b1, abort3 = 1'b0;
   logic [15:0] databus = '0;

   logic        weight_req, rd_bram, pe_enable, acc_clear, add_done, wr_en;
   logic        neuron_done, layer_done, cfg_err, busy;
   logic [15:0] weight_addr, in_addr, out_addr, lane_mask;
   logic        weight_req3, rd_bram3, pe_enable3, acc_clear3, add_done3, wr_en3;
   logic        neuron_done3, layer_done3, cfg_err3, busy3;
   logic [15:0] weight_addr3, in_addr3, out_addr3, lane_mask3;

   always #5 clk = ~clk;

   accel_layer_sequencer #(.DATA_W(16), .ADDR_W(16), .NUM_PE(NPE), .CNT_W(10), .ADD_LAT(1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .abort(abort), .databus(databus),
      .busrdwr(busrdwr), .dval(dval), .out_ready(out_ready),
      .weight_req(weight_req), .weight_addr(weight_addr), .in_addr(in_addr),
      .rd_bram(rd_bram), .pe_enable(pe_enable), .acc_clear(acc_clear),
      .lane_mask(lane_mask), .add_done(add_done), .wr_en(wr_en), .out_addr(out_addr),
      .neuron_done(neuron_done), .layer_done(layer_done), .cfg_err(cfg_err), .busy(busy)
   );

   accel_layer_sequencer #(.DATA_W(16), .ADDR_W(16), .NUM_PE(NPE), .CNT_W(10), .ADD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .enable(enable3), .abort(abort3), .databus(databus),
      .busrdwr(busrdwr), .dval(dval3), .out_ready(out_ready3),
      .weight_req(weight_req3), .weight_addr(weight_addr3), .in_addr(in_addr3),
      .rd_bram(rd_bram3), .pe_enable(pe_enable3), .acc_clear(acc_clear3),
      .lane_mask(lane_mask3), .add_done(add_done3), .wr_en(wr_en3), .out_addr(out_addr3),
      .neuron_done(neuron_done3), .layer_done(layer_done3), .cfg_err(cfg_err3), .busy(busy3)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int n_pe = 0, n_clr = 0, n_nd = 0, n_ld = 0, n_wreq = 0, n_wr = 0;
   bit dval_auto = 1'b1;

   mac_t        mac_q[$];
   logic [15:0] wr_q[$];
   int          ld_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_cnt();
      n_pe = 0; n_clr = 0; n_nd = 0; n_ld = 0; n_wreq = 0; n_wr = 0;
   endtask

   // reference model: every MAC chunk, write and layer end the descriptor should produce
   task automatic push_layer(input logic [15:0] ib, input logic [15:0] wb, input logic [15:0] ob,
                             input int nin, input int nout, input bit with_ld);
      int   ch;
      int   rm;
      mac_t e;
      ch = (nin + NPE - 1) / NPE;
      rm = nin % NPE;
      for (int n = 0; n < nout; n++) begin
         for (int c = 0; c < ch; c++) begin
            e.ia   = ib + 16'(c * NPE);
            e.wa   = wb + 16'((n * ch + c) * NPE);
            e.mask = ((c == ch - 1) && (rm != 0)) ? 16'((1 << rm) - 1) : 16'hFFFF;
            e.clr  = (c == 0);
            mac_q.push_back(e);
         end
         wr_q.push_back(ob + 16'(n));
      end
      if (with_ld) ld_q.push_back(1);
   endtask

   task automatic start(input bit sel3);
      tick();
      if (sel3) enable3 = 1'b1; else enable = 1'b1;
      tick();
      enable  = 1'b0;
      enable3 = 1'b0;
   endtask

   task automatic feed(input logic [15:0] ib, input logic [15:0] wb, input logic [15:0] ob,
                       input logic [15:0] nin, input logic [15:0] nout, input bit gap);
      logic [15:0] w [5];
      w[0] = ib; w[1] = wb; w[2] = ob; w[3] = nin; w[4] = nout;
      for (int i = 0; i < 5; i++) begin
         databus = w[i];
         busrdwr = 1'b1;
         tick();
         if (gap) begin
            busrdwr = 1'b0;
            databus = 16'hDEAD;
            tick();
         end
      end
      busrdwr = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int i = 0;
      while (busy && i < max) begin
         tick();
         i++;
      end
      check("idle_in_time", busy, 1'b0);
   endtask

   task automatic end_q(input string tag);
      check({tag, "_mac_left"}, mac_q.size(), 0);
      check({tag, "_wr_left"}, wr_q.size(), 0);
      check({tag, "_ld_left"}, ld_q.size(), 0);
   endtask

   // scoreboard monitor on the main DUT
   initial begin : monitor
      mac_t        me;
      logic [15:0] we;
      logic        prev_pe;
      prev_pe = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_pe = 1'b0;
         end else begin
            if (weight_req) n_wreq++;
            if (wr_en) n_wr++;
            check("add_done", add_done, prev_pe);
            if (pe_enable) begin
               n_pe++;
               if (acc_clear) n_clr++;
               check("rd_bram", rd_bram, 1'b1);
               check("mac_pending", mac_q.size() > 0, 1'b1);
               if (mac_q.size() > 0) begin
                  me = mac_q.pop_front();
                  check("in_addr", in_addr, me.ia);
                  check("weight_addr", weight_addr, me.wa);
                  check("lane_mask", lane_mask, me.mask);
                  check("acc_clear", acc_clear, me.clr);
               end
            end else begin
               check("idle_strobes", {rd_bram, acc_clear, lane_mask}, 18'h0);
            end
            if (neuron_done) begin
               n_nd++;
               check("nd_wr_en", wr_en, 1'b1);
               check("wr_pending", wr_q.size() > 0, 1'b1);
               if (wr_q.size() > 0) begin
                  we = wr_q.pop_front();
                  check("out_addr", out_addr, we);
               end
            end
            if (layer_done) begin
               n_ld++;
               check("ld_pending", ld_q.size() > 0, 1'b1);
               if (ld_q.size() > 0) void'(ld_q.pop_front());
            end
            prev_pe = pe_enable;
         end
      end
   end

   // weight fetcher: dval two cycles into WAIT after each request
   initial begin : fetcher
      forever begin
         tick();
         if (weight_req && dval_auto && !rst) begin
            tick();
            tick();
            dval = 1'b1;
            tick();
            dval = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int i;
      repeat (3) tick();
      check("rst_busy", busy, 1'b0);
      check("rst_cfg_err", cfg_err, 1'b0);
      check("rst_weight_addr", weight_addr, 16'h0);
      check("rst_in_addr", in_addr, 16'h0);
      check("rst_out_addr", out_addr, 16'h0);
      check("rst_strobes", {weight_req, pe_enable, rd_bram, wr_en, add_done, layer_done}, 6'h0);
      check("rst_lane_mask", lane_mask, 16'h0);
      rst = 1'b0;

      // nominal: two neurons of two full chunks
      clear_cnt();
      push_layer(16'h0100, 16'h2000, 16'h0040, 32, 2, 1'b1);
      start(1'b0);
      feed(16'h0100, 16'h2000, 16'h0040, 16'd32, 16'd2, 1'b0);
      wait_idle(300);
      check("nom_weight_end", weight_addr, 16'h2040);
      check("nom_pe", n_pe, 4);
      check("nom_clr", n_clr, 2);
      check("nom_nd", n_nd, 2);
      check("nom_ld", n_ld, 1);
      check("nom_wreq", n_wreq, 4);
      end_q("nom");

      // partial last chunk, descriptor words with idle bus cycles between them
      clear_cnt();
      push_layer(16'h0100, 16'h3000, 16'h0080, 40, 1, 1'b1);
      start(1'b0);
      feed(16'h0100, 16'h3000, 16'h0080, 16'd40, 16'd1, 1'b1);
      wait_idle(300);
      check("rem_pe", n_pe, 3);
      check("rem_weight_end", weight_addr, 16'h3030);
      check("rem_wr_cycles", n_wr, 1);
      end_q("rem");

      // write-back backpressure for five cycles
      clear_cnt();
      out_ready = 1'b0;
      push_layer(16'h0100, 16'h5000, 16'h0090, 16, 1, 1'b1);
      start(1'b0);
      feed(16'h0100, 16'h5000, 16'h0090, 16'd16, 16'd1, 1'b0);
      i = 0;
      while (!wr_en && i < 200) begin tick(); i++; end
      check("bp_wr_seen", wr_en, 1'b1);
      repeat (5) begin
         tick();
         check("bp_wr_hold", wr_en, 1'b1);
         check("bp_addr_hold", out_addr, 16'h0090);
      end
      out_ready = 1'b1;
      wait_idle(50);
      check("bp_wr_cycles", n_wr, 6);
      check("bp_nd", n_nd, 1);
      check("bp_ld", n_ld, 1);
      end_q("bp");

      // zero counts flag cfg_err; the next enable clears it
      clear_cnt();
      start(1'b0);
      feed(16'h0100, 16'h2000, 16'h0040, 16'd16, 16'd0, 1'b0);
      check("cfg_err_nout", cfg_err, 1'b1);
      check("cfg_err_idle", busy, 1'b0);
      repeat (5) tick();
      check("cfg_err_no_req", n_wreq, 0);
      start(1'b0);
      feed(16'h0100, 16'h2000, 16'h0040, 16'd0, 16'd3, 1'b0);
      check("cfg_err_nin", cfg_err, 1'b1);
      start(1'b0);
      check("cfg_err_cleared", cfg_err, 1'b0);
      check("cfg_busy", busy, 1'b1);
      push_layer(16'h0100, 16'h2000, 16'h0040, 16, 1, 1'b1);
      feed(16'h0100, 16'h2000, 16'h0040, 16'd16, 16'd1, 1'b0);
      wait_idle(100);
      check("cfg_ok_ld", n_ld, 1);
      end_q("cfg");

      // abort in WAIT of the second neuron
      clear_cnt();
      push_layer(16'h0100, 16'h2000, 16'h0040, 32, 1, 1'b0);
      start(1'b0);
      feed(16'h0100, 16'h2000, 16'h0040, 16'd32, 16'd2, 1'b0);
      i = 0;
      while (n_nd < 1 && i < 200) begin tick(); i++; end
      i = 0;
      while (!weight_req && i < 20) begin tick(); i++; end
      check("ab_req_seen", weight_req, 1'b1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_busy", busy, 1'b0);
      check("ab_wr_en", wr_en, 1'b0);
      repeat (10) tick();
      check("ab_still_idle", busy, 1'b0);
      check("ab_pe", n_pe, 2);
      check("ab_nd", n_nd, 1);
      check("ab_ld", n_ld, 0);
      end_q("ab");

      // synchronous reset during ACCUM, then a clean layer
      clear_cnt();
      push_layer(16'h0200, 16'h4000, 16'h0060, 32, 1, 1'b1);
      start(1'b0);
      feed(16'h0200, 16'h4000, 16'h0060, 16'd32, 16'd1, 1'b0);
      i = 0;
      while (!pe_enable && i < 50) begin tick(); i++; end
      check("rs_mac_seen", pe_enable, 1'b1);
      tick();
      check("rs_accum_add", add_done, 1'b1);
      rst = 1'b1;
      tick();
      check("rs_busy", busy, 1'b0);
      check("rs_addrs", {in_addr, weight_addr, out_addr}, 48'h0);
      check("rs_strobes", {weight_req, pe_enable, rd_bram, acc_clear, add_done, wr_en}, 6'h0);
      check("rs_lane_mask", lane_mask, 16'h0);
      rst = 1'b0;
      mac_q.delete();
      wr_q.delete();
      ld_q.delete();
      clear_cnt();
      push_layer(16'h0100, 16'h2000, 16'h0040, 16, 1, 1'b1);
      start(1'b0);
      feed(16'h0100, 16'h2000, 16'h0040, 16'd16, 16'd1, 1'b0);
      wait_idle(100);
      check("rs_ld", n_ld, 1);
      end_q("rs");

      // ADD_LAT=3 instance: add_done on the third ACCUM cycle
      start(1'b1);
      feed(16'h0100, 16'h2000, 16'h0040, 16'd16, 16'd1, 1'b0);
      i = 0;
      while (!weight_req3 && i < 20) begin tick(); i++; end
      check("l3_req", weight_req3, 1'b1);
      tick();
      dval3 = 1'b1;
      tick();
      dval3 = 1'b0;
      check("l3_mac", {pe_enable3, acc_clear3, lane_mask3}, {2'b11, 16'hFFFF});
      tick();
      check("l3_accum1", add_done3, 1'b0);
      tick();
      check("l3_accum2", add_done3, 1'b0);
      tick();
      check("l3_accum3", add_done3, 1'b1);
      tick();
      check("l3_write", {wr_en3, add_done3, neuron_done3, layer_done3}, 4'b1011);
      check("l3_weight_end", weight_addr3, 16'h2010);
      tick();
      check("l3_idle", busy3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
